// File: rtl/swich_alarm_debounce.sv
// swich_alarm_debounce: synchronise and debounce the alarm-enable switch, emitting clean level and edge pulses
module swich_alarm_debounce #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
) (
   input  logic clk,
   input  logic reset,
   input  logic sw_raw,
   output logic sw_stable,
   output logic rise_pulse,
   output logic fall_pulse
);
   typedef enum logic [1:0] {IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW} state_t;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic stable_q, stable_d, rise_q, rise_d, fall_q, fall_d;
   logic s;
   assign s = sync_q[SYNC_STAGES-1];
   assign sw_stable = stable_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;
   // next-state: shift the synchroniser and advance the per-transition stability counter
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], sw_raw};
      state_d = state_q;
      cnt_d = '0;
      stable_d = stable_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      unique case (state_q)
         IDLE_LOW: begin
            state_d = s ? WAIT_HIGH : IDLE_LOW;
            cnt_d = s ? CNT_ONE : '0;
         end
         WAIT_HIGH: begin
            if (!s) state_d = IDLE_LOW;
            else if (cnt_q == CNT_MAX) begin
               state_d = IDLE_HIGH;
               stable_d = 1'b1;
               rise_d = 1'b1;
            end else cnt_d = cnt_q + CNT_ONE;
         end
         IDLE_HIGH: begin
            state_d = s ? IDLE_HIGH : WAIT_LOW;
            cnt_d = s ? '0 : CNT_ONE;
         end
         WAIT_LOW: begin
            if (s) state_d = IDLE_HIGH;
            else if (cnt_q == CNT_MAX) begin
               state_d = IDLE_LOW;
               stable_d = 1'b0;
               fall_d = 1'b1;
            end else cnt_d = cnt_q + CNT_ONE;
         end
         default: state_d = IDLE_LOW;
      endcase
   end
   // register all state and outputs; reset wins over any pending qualification
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
         state_q <= IDLE_LOW;
         cnt_q <= '0;
         stable_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         state_q <= state_d;
         cnt_q <= cnt_d;
         stable_q <= stable_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end
endmodule

// File: tb/tb_swich_alarm_debounce.sv
// tb_swich_alarm_debounce: random and directed stimulus checked against a run-length debounce model
module tb_swich_alarm_debounce;
   localparam int SYNC = 2;
   localparam int DEB = 4;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic sw_raw = 1'b0;
   logic sw_stable, rise_pulse, fall_pulse;
   int n_vec = 0;
   int n_bad = 0;
   logic [SYNC-1:0] m_pipe = '0;
   logic m_stable = 1'b0;
   logic m_rise = 1'b0;
   logic m_fall = 1'b0;
   int m_run = 0;

   swich_alarm_debounce #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .CNT_W(3)) dut (
      .clk(clk), .reset(reset), .sw_raw(sw_raw),
      .sw_stable(sw_stable), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic got, input logic exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
      end
   endtask

   // one clock: drive inputs, advance the model, compare outputs just after the edge
   task automatic step(input logic r, input logic sw);
      logic s;
      @(negedge clk);
      reset = r;
      sw_raw = sw;
      @(posedge clk);
      if (r) begin
         m_pipe = '0;
         m_stable = 1'b0;
         m_run = 0;
         m_rise = 1'b0;
         m_fall = 1'b0;
      end else begin
         s = m_pipe[SYNC-1];
         m_pipe = {m_pipe[SYNC-2:0], sw};
         m_rise = 1'b0;
         m_fall = 1'b0;
         m_run = (s != m_stable) ? m_run + 1 : 0;
         if (m_run == DEB) begin
            m_stable = ~m_stable;
            m_rise = m_stable;
            m_fall = ~m_stable;
            m_run = 0;
         end
      end
      #1;
      chk("sw_stable", sw_stable, m_stable);
      chk("rise_pulse", rise_pulse, m_rise);
      chk("fall_pulse", fall_pulse, m_fall);
      chk("no_overlap", rise_pulse & fall_pulse, 1'b0);
   endtask

   task automatic hold(input logic sw, input int n);
      for (int i = 0; i < n; i++) step(1'b0, sw);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
      hold(1'b0, 5);
      hold(1'b1, 10);
      hold(1'b0, 10);
      hold(1'b1, 3);
      hold(1'b0, 2);
      hold(1'b1, 3);
      hold(1'b0, 10);
      hold(1'b1, 4);
      hold(1'b0, 12);
      hold(1'b1, 3);
      step(1'b1, 1'b1);
      hold(1'b1, 10);
      hold(1'b0, 10);
      for (int i = 0; i < 2; i++) step(1'b1, 1'b1);
      hold(1'b1, 20);
      for (int k = 0; k < 400; k++) begin
         logic lvl;
         int len;
         lvl = 1'($urandom_range(1, 0));
         len = $urandom_range(8, 1);
         if ($urandom_range(39, 0) == 0) step(1'b1, lvl);
         hold(lvl, len);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
